if_fetch: RTL and testbench

Instruction-fetch stage directly downstream of the program-counter register. It takes the current PC, issues in-order requests to instruction memory with a request/grant handshake, and buffers returned instructions with their PCs in a DEPTH-entry in-order queue. It presents them to decode with a valid/ready handshake. On a taken jump it squashes all wrong-path work and tells the PC register when to hold.

---
 rtl/if_fetch.sv | 119 +++++++++++
 tb/tb_if_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: in-order imem request/grant, DEPTH-entry return queue,
// valid/ready presentation to decode, and jump flush with stale-return dropping.
module if_fetch #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        jump_en_i,
  output logic        pc_hold_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]   filled_q, filled_d;
  logic [PW-1:0]      alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
  logic [CW-1:0]      count_q, count_d, unfilled_q, unfilled_d, drop_cnt_q, drop_cnt_d;
  logic               accept, fill, pop, credit;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit counts both live unfilled slots and returns still owed from before a flush.
  assign credit      = ({1'b0, drop_cnt_q} + {1'b0, unfilled_q}) < DEPTH_W;
  assign imem_req_o  = !rst && !jump_en_i && ({1'b0, count_q} < DEPTH_W) && credit;
  assign imem_addr_o = pc_i;
  assign accept      = imem_req_o && imem_gnt_i;
  assign pc_hold_o   = !accept;
  assign fill        = imem_rvalid_i && (drop_cnt_q == '0) && (unfilled_q != '0);

  assign id_valid_o  = !rst && (count_q != '0) && filled_q[head_q] && !jump_en_i;
  assign id_pc_o     = rst ? '0 : ent_q[head_q].pc;
  assign id_inst_o   = rst ? '0 : ent_q[head_q].inst;
  assign pop         = id_valid_o && id_ready_i;

  always_comb begin
    ent_d      = ent_q;
    filled_d   = filled_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    drop_cnt_d = drop_cnt_q;
    if (jump_en_i) begin
      filled_d   = '0;
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
      // A return arriving in the flush cycle is already gone; a stray one is ignored.
      drop_cnt_d = drop_cnt_q + unfilled_q
                 - CW'(imem_rvalid_i && (drop_cnt_q != '0 || unfilled_q != '0));
    end else begin
      if (accept) begin
        ent_d[alloc_q].pc = pc_i;
        filled_d[alloc_q] = 1'b0;
        alloc_d           = inc(alloc_q);
      end
      if (imem_rvalid_i && drop_cnt_q != '0)
        drop_cnt_d = drop_cnt_q - CW'(1);
      if (fill) begin
        ent_d[fill_q].inst = imem_rdata_i;
        filled_d[fill_q]   = 1'b1;
        fill_d             = inc(fill_q);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = inc(head_q);
      end
      count_d    = count_q + CW'(accept) - CW'(pop);
      unfilled_d = unfilled_q + CW'(accept) - CW'(fill);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q      <= '0;
      filled_q   <= '0;
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      ent_q      <= ent_d;
      filled_q   <= filled_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ap_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid_i && drop_cnt_q == '0 && unfilled_q == '0));

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: PC-register and latency-k memory models, vector table
// for reset/stream start, hand sequences for backpressure, stall, flush and reset.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst, jump_en_i, imem_gnt_i, imem_rvalid_i, id_ready_i;
  logic [31:0] pc_i, imem_rdata_i;
  logic        pc_hold_o, imem_req_o, id_valid_o;
  logic [31:0] imem_addr_o, id_pc_o, id_inst_o;

  always #5 clk = ~clk;

  if_fetch #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .jump_en_i(jump_en_i), .pc_hold_o(pc_hold_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o)
  );

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic rst, gnt, rdy;
    logic exp_req, exp_hold, exp_val;
    logic [31:0] exp_pc;
  } vec_t;

  mreq_t       mq[$];
  vec_t        vt[9];
  int          n_chk = 0, n_pass = 0, cyc = 0, lat = 1;
  logic [31:0] rst_pc = '0, jmp_tgt = '0, exp_pc = '0, p0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
  endtask

  // One clock: sample handshakes before the edge, then advance PC reg and memory.
  task automatic cycle();
    logic acc, rv, hold, rs, jmp;
    logic [31:0] addr;
    acc = imem_req_o & imem_gnt_i; rv = imem_rvalid_i; hold = pc_hold_o;
    rs = rst; jmp = jump_en_i; addr = imem_addr_o;
    @(posedge clk); #1; cyc++;
    if (rs) begin
      mq.delete();
      pc_i = rst_pc;
    end else begin
      if (rv) mq.delete(0);
      if (acc) mq.push_back('{addr: addr, due: cyc - 1 + lat});
      if (jmp) pc_i = jmp_tgt;
      else if (!hold) pc_i = pc_i + 32'd4;
    end
    imem_rvalid_i = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rdata_i  = imem_rvalid_i ? (mq[0].addr ^ KEY) : '0;
  endtask

  task automatic obs();
    if (id_valid_o) begin
      chk("stream_pc", id_pc_o, exp_pc);
      chk("stream_inst", id_inst_o, exp_pc ^ KEY);
      if (id_ready_i) exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin #1; obs(); cycle(); end
  endtask

  task automatic do_reset(input logic [31:0] rp);
    rst = 1'b1; jump_en_i = 1'b0; imem_gnt_i = 1'b1; rst_pc = rp;
    #1; cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; jump_en_i = 1'b0; imem_gnt_i = 1'b1; id_ready_i = 1'b1;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; pc_i = '0;

    // Reset, then k=1 streaming: two accepts, then a 3-cycle present pattern.
    vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8};
    vt[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC};
    vt[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      rst = vt[i].rst; imem_gnt_i = vt[i].gnt; id_ready_i = vt[i].rdy;
      #1;
      chkb($sformatf("v%0d_req", i), imem_req_o, vt[i].exp_req);
      chkb($sformatf("v%0d_hold", i), pc_hold_o, vt[i].exp_hold);
      chkb($sformatf("v%0d_valid", i), id_valid_o, vt[i].exp_val);
      chk($sformatf("v%0d_addr", i), imem_addr_o, pc_i);
      if (vt[i].rst || vt[i].exp_val) begin
        chk($sformatf("v%0d_pc", i), id_pc_o, vt[i].exp_pc);
        chk($sformatf("v%0d_inst", i), id_inst_o, vt[i].rst ? 32'h0 : (vt[i].exp_pc ^ KEY));
      end
      cycle();
    end
    exp_pc = 32'h10;
    stream(8);
    chk("stream_end", exp_pc, 32'h28);

    // Grant stall: PC must hold and nothing is lost.
    p0 = pc_i; imem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chkb("stall_hold", pc_hold_o, 1'b1); chk("stall_pc", pc_i, p0); obs(); cycle();
    end
    imem_gnt_i = 1'b1;
    stream(10);
    chk("stall_resume", exp_pc, 32'h44);

    // Backpressure: head held stable, queue fills, fetch stops.
    lat = 1; id_ready_i = 1'b0; do_reset(32'h0);
    for (int i = 0; i < 2; i++) begin #1; cycle(); end
    for (int i = 0; i < 6; i++) begin
      #1;
      chkb("bp_valid", id_valid_o, 1'b1); chk("bp_pc", id_pc_o, 32'h0);
      chk("bp_inst", id_inst_o, KEY);
      chkb("bp_req", imem_req_o, 1'b0); chkb("bp_hold", pc_hold_o, 1'b1);
      cycle();
    end
    id_ready_i = 1'b1; exp_pc = 32'h0;
    stream(8);
    chk("bp_release", exp_pc, 32'h18);

    // Flush with two requests in flight, k=3.
    lat = 3; id_ready_i = 1'b1; do_reset(32'h0);
    for (int i = 0; i < 2; i++) begin #1; cycle(); end
    jump_en_i = 1'b1; jmp_tgt = 32'h100;
    #1;
    chkb("fl_valid", id_valid_o, 1'b0); chkb("fl_req", imem_req_o, 1'b0);
    chkb("fl_hold", pc_hold_o, 1'b1);
    cycle();
    jump_en_i = 1'b0;
    #1;
    chk("fl_drop2", 32'(dut.drop_cnt_q), 32'd2); chkb("fl_nocredit", imem_req_o, 1'b0);
    cycle();
    #1;
    chkb("fl_req_tgt", imem_req_o, 1'b1); chk("fl_addr_tgt", imem_addr_o, 32'h100);
    cycle();
    chk("fl_drop0", 32'(dut.drop_cnt_q), 32'd0);
    exp_pc = 32'h100;
    stream(10);
    chk("fl_stream", exp_pc, 32'h110);

    // Flush coincident with rvalid and a ready decode.
    lat = 1; id_ready_i = 1'b1; do_reset(32'h0);
    for (int i = 0; i < 2; i++) begin #1; cycle(); end
    jump_en_i = 1'b1; jmp_tgt = 32'h200;
    #1;
    chkb("fr_valid", id_valid_o, 1'b0); chkb("fr_req", imem_req_o, 1'b0);
    cycle();
    jump_en_i = 1'b0;
    #1;
    chk("fr_drop", 32'(dut.drop_cnt_q), 32'd0); chkb("fr_req_next", imem_req_o, 1'b1);
    chk("fr_addr", imem_addr_o, 32'h200); chkb("fr_valid_next", id_valid_o, 1'b0);
    cycle();
    exp_pc = 32'h200;
    stream(6);
    chk("fr_stream", exp_pc, 32'h210);

    // Reset while the queue is full, restart at a new PC.
    lat = 1; id_ready_i = 1'b0; do_reset(32'h0);
    for (int i = 0; i < 3; i++) begin #1; cycle(); end
    rst = 1'b1; rst_pc = 32'h400;
    #1;
    chkb("rm_req", imem_req_o, 1'b0); chkb("rm_hold", pc_hold_o, 1'b1);
    chkb("rm_valid", id_valid_o, 1'b0); chk("rm_pc", id_pc_o, 32'h0); chk("rm_inst", id_inst_o, 32'h0);
    cycle();
    rst = 1'b0; id_ready_i = 1'b1;
    #1;
    chk("rm_count", 32'(dut.count_q), 32'd0); chkb("rm_valid_after", id_valid_o, 1'b0);
    chk("rm_addr", imem_addr_o, 32'h400);
    cycle();
    exp_pc = 32'h400;
    stream(6);
    chk("rm_stream", exp_pc, 32'h410);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
